// File: rtl/sram_port_arbiter_if.sv
// Requester-side and SRAM-side signals of the two-port SRAM arbiter.
// slave = the arbiter's view, master = the requesters/SRAM environment.
interface sram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    logic                  p0Request;
    logic                  p0Lock;
    logic                  p0WriteEnable;
    logic [ADDR_WIDTH-1:0] p0Address;
    logic [DATA_WIDTH-1:0] p0DataIn;
    logic                  p0Grant;
    logic                  p0ReadValid;
    logic [DATA_WIDTH-1:0] p0DataOut;

    logic                  p1Request;
    logic                  p1Lock;
    logic                  p1WriteEnable;
    logic [ADDR_WIDTH-1:0] p1Address;
    logic [DATA_WIDTH-1:0] p1DataIn;
    logic                  p1Grant;
    logic                  p1ReadValid;
    logic [DATA_WIDTH-1:0] p1DataOut;

    logic                  sramWriteEnable;
    logic [ADDR_WIDTH-1:0] sramAddress;
    logic [DATA_WIDTH-1:0] sramDataIn;
    logic [DATA_WIDTH-1:0] sramDataOut;

    modport slave (
        input  p0Request, p0Lock, p0WriteEnable, p0Address, p0DataIn,
        input  p1Request, p1Lock, p1WriteEnable, p1Address, p1DataIn,
        input  sramDataOut,
        output p0Grant, p0ReadValid, p0DataOut,
        output p1Grant, p1ReadValid, p1DataOut,
        output sramWriteEnable, sramAddress, sramDataIn
    );

    modport master (
        output p0Request, p0Lock, p0WriteEnable, p0Address, p0DataIn,
        output p1Request, p1Lock, p1WriteEnable, p1Address, p1DataIn,
        output sramDataOut,
        input  p0Grant, p0ReadValid, p0DataOut,
        input  p1Grant, p1ReadValid, p1DataOut,
        input  sramWriteEnable, sramAddress, sramDataIn
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter for one single-port synchronous SRAM with bounded lock.
// SRAM_ARB_ROUND_ROBIN_EN selects round-robin contention; default is fixed priority to port 0.
module sram_port_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 16
) (
    input  logic                clock,
    input  logic                nReset,
    sram_port_arbiter_if.slave  bus
);
    localparam int COUNT_WIDTH = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {OWNER_NONE, OWNER_P0, OWNER_P1} owner_t;

    owner_t                 lockOwner;
    logic [COUNT_WIDTH-1:0] lockCount;
    logic                   lastGrant;
    logic                   readValid0Reg;
    logic                   readValid1Reg;

    logic                   grant0;
    logic                   grant1;
    logic                   lockExhausted;
    logic [ADDR_WIDTH-1:0]  selAddress;
    logic [DATA_WIDTH-1:0]  selData;

    assign lockExhausted = (lockCount == COUNT_WIDTH'(LOCK_MAX));

    // An exhausted lock hands the next cycle to the waiting port in both builds,
    // otherwise fixed priority would let port 0 starve port 1 indefinitely.
    always_comb begin
        // NOTE: defaults first so every path assigns both grants and no latch is inferred.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!nReset) begin
            grant0 = 1'b0;
        end else if (lockOwner == OWNER_P0 && bus.p0Request) begin
            grant0 = !lockExhausted || !bus.p1Request;
            grant1 = lockExhausted && bus.p1Request;
        end else if (lockOwner == OWNER_P1 && bus.p1Request) begin
            grant1 = !lockExhausted || !bus.p0Request;
            grant0 = lockExhausted && bus.p0Request;
        end else if (bus.p0Request && bus.p1Request) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            grant0 = lastGrant;
            grant1 = !lastGrant;
`else
            grant0 = 1'b1;
`endif
        end else begin
            grant0 = bus.p0Request;
            grant1 = bus.p1Request;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!nReset) begin
            lastGrant     <= 1'b1;
            lockOwner     <= OWNER_NONE;
            lockCount     <= '0;
            readValid0Reg <= 1'b0;
            readValid1Reg <= 1'b0;
        end else begin
            lastGrant     <= (grant0 || grant1) ? grant1 : lastGrant;
            readValid0Reg <= grant0 && !bus.p0WriteEnable;
            readValid1Reg <= grant1 && !bus.p1WriteEnable;
            if (grant0 && bus.p0Lock) begin
                lockOwner <= OWNER_P0;
                if (lockOwner != OWNER_P0)
                    lockCount <= COUNT_WIDTH'(1);
                else if (!lockExhausted)
                    lockCount <= lockCount + COUNT_WIDTH'(1);
            end else if (grant1 && bus.p1Lock) begin
                lockOwner <= OWNER_P1;
                if (lockOwner != OWNER_P1)
                    lockCount <= COUNT_WIDTH'(1);
                else if (!lockExhausted)
                    lockCount <= lockCount + COUNT_WIDTH'(1);
            end else begin
                lockOwner <= OWNER_NONE;
                lockCount <= '0;
            end
        end
    end

    // With no grant the address/data follow port 0; the SRAM ignores them.
    assign selAddress = grant1 ? bus.p1Address : bus.p0Address;
    assign selData    = grant1 ? bus.p1DataIn  : bus.p0DataIn;

    assign bus.p0Grant         = grant0;
    assign bus.p1Grant         = grant1;
    assign bus.sramWriteEnable = (grant0 && bus.p0WriteEnable) || (grant1 && bus.p1WriteEnable);
    assign bus.sramAddress     = selAddress;
    assign bus.sramDataIn      = selData;

    assign bus.p0ReadValid = readValid0Reg && nReset;
    assign bus.p1ReadValid = readValid1Reg && nReset;
    assign bus.p0DataOut   = bus.p0ReadValid ? bus.sramDataOut : '0;
    assign bus.p1DataOut   = bus.p1ReadValid ? bus.sramDataOut : '0;
endmodule
